// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter.
//   arb_state_e : arbiter FSM states
//   arb_op_e    : operation latched for the granted request
//   idx_width() : width of a port index (at least 1 bit)
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker.
//   req       : per-port request vector
//   ptr       : highest-priority port index (always < NUM_PORTS)
//   grant_idx : first requesting port at or after ptr, wrapping
//   valid     : at least one port is requesting
module rr_select #(
  parameter int NUM_PORTS = 2,
  parameter int PTR_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [PTR_W-1:0]     grant_idx,
  output logic                 valid
);

  // Two descending scans: the first finds the lowest requester overall
  // (the wrap-around winner), the second overrides it with the lowest
  // requester at or above ptr when one exists.
  always_comb begin
    grant_idx = '0;
    valid     = |req;
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      if (req[j]) grant_idx = PTR_W'(j);
    end
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      if (req[j] && (PTR_W'(j) >= ptr)) grant_idx = PTR_W'(j);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one downstream memory port among NUM_PORTS
// requesters, one transaction at a time.
//   clk, rst           : clock, synchronous active-low reset
//   req_addr/read/write/wmask/wdata : per-port requests, strobes held until resp
//   req_rdata, req_resp: per-port completion (combinational from mem_resp)
//   mem_addr/read/write/wmask/wdata : downstream request, from latched regs
//   mem_rdata, mem_resp: downstream completion
//   error              : sticky protocol / timeout flag
//
// state | meaning
// IDLE  | no transaction; pick next requester at or after rr_ptr
// BUSY  | latched request driven downstream, waiting for mem_resp
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS-1:0]                  req_read,
  input  logic [NUM_PORTS-1:0]                  req_write,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] req_wmask,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_rdata,
  output logic [NUM_PORTS-1:0]                  req_resp,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic                                  mem_read,
  output logic                                  mem_write,
  output logic [DATA_WIDTH/8-1:0]               mem_wmask,
  output logic [DATA_WIDTH-1:0]                 mem_wdata,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata,
  input  logic                                  mem_resp,
  output logic                                  error
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W      = idx_width(NUM_PORTS);
  localparam int CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_PORTS - 1);

  arb_state_e            state_q, state_d;
  arb_op_e               op_q, op_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  error_q, error_d;

  logic [NUM_PORTS-1:0]  req_any;
  logic [PTR_W-1:0]      sel_idx;
  logic                  sel_valid;

  assign req_any = req_read | req_write;

  rr_select #(
    .NUM_PORTS(NUM_PORTS),
    .PTR_W    (PTR_W)
  ) u_rr_select (
    .req      (req_any),
    .ptr      (rr_ptr_q),
    .grant_idx(sel_idx),
    .valid    (sel_valid)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    wmask_d   = wmask_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    error_d   = error_q | (|(req_read & req_write));
    req_resp  = '0;
    req_rdata = '0;

    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d = BUSY;
          grant_d = sel_idx;
          // read+write together is a protocol error but still serviced as a read
          op_d    = req_read[sel_idx] ? OP_READ : OP_WRITE;
          addr_d  = req_addr[sel_idx];
          wmask_d = req_wmask[sel_idx];
          wdata_d = req_wdata[sel_idx];
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_MAX) error_d = 1'b1;
        if (!req_any[grant_q]) error_d = 1'b1;
        if (mem_resp) begin
          req_resp[grant_q]  = 1'b1;
          req_rdata[grant_q] = mem_rdata;
          state_d            = IDLE;
          rr_ptr_d           = (grant_q == LAST_PORT) ? '0 : grant_q + PTR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= OP_READ;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      wmask_q  <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      wmask_q  <= wmask_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      error_q  <= error_d;
    end
  end

  assign mem_read  = (state_q == BUSY) && (op_q == OP_READ);
  assign mem_write = (state_q == BUSY) && (op_q == OP_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wmask = wmask_q;
  assign mem_wdata = wdata_q;
  assign error     = error_q;

endmodule
